// File: rtl/pipe_unmul.sv
// Restoring divider recovering X3 = F / D from a pipeline result F = X3 * D.
// Optional `PIPE_UNMUL_EXACT_CHECK_EN adds an inexact flag (R != 0 or D == 0).
module pipe_unmul #(
  parameter int N = 100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] F,
  input  logic [N-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         div_zero
`ifdef PIPE_UNMUL_EXACT_CHECK_EN
  ,
  output logic         inexact
`endif
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dz_q, dz_d;

  // rem < D always holds, so the top bit of sh is 0 and
  // trial[N+1] is a clean borrow flag.
  logic [N+1:0]  sh;
  logic [N+1:0]  trial;
  logic          neg;

  assign sh    = {rem_q, dvd_q[N-1]};
  assign trial = sh - {2'b0, dvs_q};
  assign neg   = trial[N+1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = F;
          dvs_d = D;
          rem_d = '0;
          cnt_d = '0;
          if (D == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = F;
            dz_d    = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = neg ? sh[N:0] : trial[N:0];
        dvd_d = {dvd_q[N-2:0], ~neg};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          q_d     = dvd_d;
          r_d     = rem_d[N-1:0];
          dz_d    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

`ifdef PIPE_UNMUL_EXACT_CHECK_EN
  logic inx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inx_q <= 1'b0;
    end else if (state_q != DONE && state_d == DONE) begin
      inx_q <= dz_d | (|r_d);
    end
  end

  assign inexact = inx_q;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Q         = q_q;
  assign R         = r_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_pipe_unmul.sv
// Scoreboard bench for pipe_unmul: directed vectors, decoupled monitor.
// Covers latency, backpressure, divide-by-zero and async reset mid-run.
module tb_pipe_unmul;

  localparam int N = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] F;
  logic [N-1:0] D;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Q;
  logic [N-1:0] R;
  logic         div_zero;
`ifdef PIPE_UNMUL_EXACT_CHECK_EN
  logic         inexact;
`endif

  pipe_unmul #(.N(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .F(F),
    .D(D),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Q(Q),
    .R(R),
    .div_zero(div_zero)
`ifdef PIPE_UNMUL_EXACT_CHECK_EN
    ,
    .inexact(inexact)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         inx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  function automatic void chk(input string name,
                              input logic [N-1:0] act,
                              input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: a handshake happens at the next edge when both are high here
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got output Q=%0d expected none", Q);
      end else begin
        e = sb.pop_front();
        chk("Q", Q, e.q);
        chk("R", R, e.r);
        chk("div_zero", N'(div_zero), N'(e.dz));
`ifdef PIPE_UNMUL_EXACT_CHECK_EN
        chk("inexact", N'(inexact), N'(e.inx));
`endif
      end
    end
  end

  task automatic issue(input logic [N-1:0] f, input logic [N-1:0] d,
                       input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input logic einx,
                       output int acc);
    logic rdy;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    F = f;
    D = d;
    acc = -1;
    for (int i = 0; i < 400; i++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept");
    end else begin
      e.q = eq;
      e.r = er;
      e.dz = edz;
      e.inx = einx;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid(input int acc, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) begin
        lat = cyc - acc + 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no out_valid expected out_valid");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && out_valid; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int acc, lat, hs;
  logic [N-1:0] ones;

  initial begin
    ones      = '1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    F         = '0;
    D         = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", N'(in_ready), N'(1));
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_Q", Q, '0);
    chk("rst_R", R, '0);
    chk("rst_div_zero", N'(div_zero), N'(0));
    rst_n = 1'b1;

    // basic: latency N+1
    issue(75, 3, 25, 0, 0, 0, acc);
    wait_valid(acc, lat);
    chk("lat_75_3", N'(lat), N'(N + 1));
    drain();

    // back-to-back
    issue(66, 3, 22, 0, 0, 0, acc);
    wait_valid(acc, lat);
    hs = cyc + 1;
    issue(112, 4, 28, 0, 0, 0, acc);
    chk("b2b_gap_ok", N'(acc - hs + 1 >= 2), N'(1));
    wait_valid(acc, lat);
    drain();

    // remainders
    issue(76, 3, 25, 1, 0, 1, acc);
    wait_valid(acc, lat);
    drain();
    issue(5, 7, 0, 5, 0, 1, acc);
    wait_valid(acc, lat);
    drain();
    issue(9, 9, 1, 0, 0, 0, acc);
    wait_valid(acc, lat);
    drain();
    issue(ones, 1, ones, 0, 0, 0, acc);
    wait_valid(acc, lat);
    drain();

    // divide by zero
    issue(75, 0, ones, 75, 1, 1, acc);
    wait_valid(acc, lat);
    chk("lat_div0", N'(lat), N'(1));
    drain();

    // backpressure
    out_ready = 1'b0;
    issue(75, 3, 25, 0, 0, 0, acc);
    wait_valid(acc, lat);
    for (int i = 0; i < 20; i++) begin
      chk("bp_Q", Q, 25);
      chk("bp_out_valid", N'(out_valid), N'(1));
      chk("bp_in_ready", N'(in_ready), N'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_out_valid", N'(out_valid), N'(0));
    chk("bp_rel_in_ready", N'(in_ready), N'(1));

    // async reset at cycle 40 of RUN
    issue(75, 3, 25, 0, 0, 0, acc);
    repeat (39) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", N'(in_ready), N'(1));
    chk("arst_out_valid", N'(out_valid), N'(0));
    chk("arst_Q", Q, '0);
    chk("arst_R", R, '0);
    chk("arst_div_zero", N'(div_zero), N'(0));
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(10, 2, 5, 0, 0, 0, acc);
    wait_valid(acc, lat);
    chk("lat_10_2", N'(lat), N'(N + 1));
    drain();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", N'(sb.size()), N'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
